// File: rtl/fetch_stage_pkg.sv
// Shared core package: reset PC default, instruction width and the
// {pc, inst} fetch-entry bundle handed from fetch to decode.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam int          INST_W           = 32;
    localparam int          PC_W             = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fs_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-decode handshake: head entry plus valid, decode answers allowin.
// master = fetch side (drives valid/pc/inst), slave = decode side.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              fs_to_ds_valid;
    logic [PC_W-1:0]   fs_to_ds_pc;
    logic [INST_W-1:0] fs_to_ds_inst;
    logic              ds_allowin;

    modport master (
        output fs_to_ds_valid,
        output fs_to_ds_pc,
        output fs_to_ds_inst,
        input  ds_allowin
    );

    modport slave (
        input  fs_to_ds_valid,
        input  fs_to_ds_pc,
        input  fs_to_ds_inst,
        output ds_allowin
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Synchronous instruction FIFO with flush; DEPTH must be a power of two.
// Ports: clk, resetn, flush/push/pop, din/dout, count, empty, full.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential PC, SRAM request, 1-deep in-flight
// tracking, redirect flush. Ports: clk/resetn, inst_sram_*, br_*, ds (master).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         resetn,
    output logic         inst_sram_en,
    output logic [3:0]   inst_sram_we,
    output logic [31:0]  inst_sram_addr,
    output logic [31:0]  inst_sram_wdata,
    input  logic [31:0]  inst_sram_rdata,
    input  logic         br_valid,
    input  logic [31:0]  br_target,
    fetch_stage_if.master ds
);

    localparam int          CW      = $clog2(IBUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(IBUF_DEPTH);

    logic [31:0]   last_pc;
    logic [31:0]   infl_pc;
    logic          inflight;
    logic [31:0]   fetch_addr;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    fs_entry_t     push_entry;
    fs_entry_t     head;

    assign pop  = ds.fs_to_ds_valid & ds.ds_allowin;
    assign push = inflight & ~br_valid;

    // Occupancy after this cycle counts the in-flight slot, so a request
    // is only made when its response is guaranteed a FIFO entry.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue = br_valid | (occ < DEPTH_V);

    assign fetch_addr = br_valid ? align_pc(br_target) : last_pc + 32'd4;

    assign inst_sram_en    = issue & resetn;
    assign inst_sram_addr  = fetch_addr;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;

    assign push_entry = '{pc: infl_pc, inst: inst_sram_rdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_pc  <= RESET_PC - 32'd4;
            infl_pc  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                last_pc <= fetch_addr;
                infl_pc <= fetch_addr;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (IBUF_DEPTH),
        .WIDTH ($bits(fs_entry_t))
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (br_valid),
        .push   (push),
        .pop    (pop),
        .din    (push_entry),
        .dout   (head),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    assign ds.fs_to_ds_valid = ~empty;
    assign ds.fs_to_ds_pc    = head.pc;
    assign ds.fs_to_ds_inst  = head.inst;

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(push && full));
        end
    end

endmodule
